hc_csr_bank: RTL and testbench
==============================

HC_CSR_BANK -- requirements
Module: hc_csr_bank

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 4, number of buffer descriptors (legal 1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h120, byte address of descriptor 0.
REQ-003 SHALL have parameter SIZE_W, default 32, width of each buffer size field.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port mmio_wr_valid, input, 1, MMIO write request valid.
REQ-007 SHALL have port mmio_rd_valid, input, 1, MMIO read request valid.
REQ-008 SHALL have port mmio_addr, input, 16, dword address (byte address >> 2).
REQ-009 SHALL have port mmio_tid, input, 9, read transaction id.
REQ-010 SHALL have port mmio_wdata, input, 64, write data.
REQ-011 SHALL have port rsp_valid, output, 1, read response valid.
REQ-012 SHALL have port rsp_tid, output, 9, echoed tid.
REQ-013 SHALL have port rsp_data, output, 64, read data.
REQ-014 SHALL have port dsm_base, output, 64, DSM base address.
REQ-015 SHALL have port buf_addr, output, 64*NUM_BUFFERS, descriptor addresses; descriptor i is in bits [64i+63:64i].
REQ-016 SHALL have port buf_size, output, SIZE_W*NUM_BUFFERS, descriptor sizes, packed the same way.
REQ-017 SHALL have port ctl_state, output, 2, control FSM state.
REQ-018 SHALL have ports start_pulse and stop_pulse, output, 1 each, one-cycle event strobes.

Function
REQ-019 SHALL decode the byte map: DSM 0x110, CONTROL 0x118, descriptor i address at BASE_ADDR+0x10*i, descriptor i size at BASE_ADDR+0x10*i+0x8.
REQ-020 SHALL accept writes only when mmio_addr[0]=0 and the byte address is below 0x400; all other writes are ignored.
REQ-021 SHALL update the addressed register on the clock edge after mmio_wr_valid; a size write takes mmio_wdata[SIZE_W-1:0].
REQ-022 SHALL ignore writes to descriptor indices >= NUM_BUFFERS.
REQ-023 SHALL implement an FSM with states IDLE=0, READY=1, RUN=2, DONE=3.
REQ-024 SHALL apply CONTROL write data[31:0] as follows: 0x0 from any state -> IDLE; 0x1 IDLE->READY; 0x3 READY->RUN with start_pulse=1 for one cycle; 0x7 RUN->DONE with stop_pulse=1 for one cycle; 0x1 DONE->READY.
REQ-025 SHALL ignore any other CONTROL value, and any listed value not legal in the current state, with no state change.
REQ-026 SHALL ignore descriptor and DSM writes while ctl_state=RUN.
REQ-027 SHALL assert rsp_valid exactly one cycle after mmio_rd_valid, with rsp_tid equal to the request tid.
REQ-028 SHALL answer every read, including unmapped or odd addresses; unmapped reads return 64'h0.
REQ-029 SHALL, when a read and a write hit the same register in one cycle, return the pre-write value.
REQ-030 SHALL return {62'h0, ctl_state} for a CONTROL read.

Reset
REQ-031 SHALL, on reset, clear dsm_base, all buf_addr and buf_size, rsp_valid, rsp_tid, rsp_data, start_pulse and stop_pulse to 0 and set ctl_state to IDLE.
REQ-032 SHALL have reset override any simultaneous MMIO request, so that no response is issued for a read accepted in the reset cycle.
REQ-033 SHALL have reset during RUN produce no stop_pulse.

Configuration
REQ-034 SHALL, with HC_CSR_READBACK_EN defined, return the current register contents for reads of DSM, CONTROL and descriptor registers.
REQ-035 SHALL, with HC_CSR_READBACK_EN undefined, return 64'h0 for every read while keeping the same response timing and tid echo.

Verification
REQ-036 SHALL cover: write 0x1000 to byte 0x120, then 0x40 to byte 0x128 -> buf_addr[0]=0x1000 and buf_size[0]=0x40 next cycle.
REQ-037 SHALL cover: CONTROL writes 0x1, 0x3, 0x7 -> ctl_state 1, 2, 3; start_pulse one cycle after the 0x3 write and stop_pulse one cycle after the 0x7 write.
REQ-038 SHALL cover: in RUN, write 0xBEEF to byte 0x130 -> buf_addr[1] unchanged; CONTROL 0x3 in IDLE -> state stays 0.
REQ-039 SHALL cover: with NUM_BUFFERS=4, write to byte 0x160 -> no register changes; read of 0x160 with tid 0x55 -> rsp_valid=1, rsp_tid=0x55, rsp_data=0.
REQ-040 SHALL cover: with readback enabled, read byte 0x110 after DSM=0xABCD000 -> rsp_data=0xABCD000 one cycle later; with readback disabled the same read -> 0.
REQ-041 SHALL cover: reset asserted while in RUN with a read pending -> ctl_state=0, all outputs 0, and no rsp_valid.

Source files
------------

// File: rtl/hc_csr_bank.sv
// hc_csr_bank: MMIO control/status register bank for a host channel.
// Holds the DSM base address, a small FSM driven through a CONTROL register,
// and NUM_BUFFERS buffer descriptors (64-bit address + SIZE_W-bit size).
// Every read is answered exactly one cycle after it is accepted.
// Optional feature: define HC_CSR_READBACK_EN to return register contents on
// reads; without it every read returns zero with the same timing and tid echo.
module hc_csr_bank #(
  parameter int          NUM_BUFFERS = 4,
  parameter logic [15:0] BASE_ADDR   = 16'h120,
  parameter int          SIZE_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_wr_valid,
  input  logic                          mmio_rd_valid,
  input  logic [15:0]                   mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wdata,
  output logic                          rsp_valid,
  output logic [8:0]                    rsp_tid,
  output logic [63:0]                   rsp_data,
  output logic [63:0]                   dsm_base,
  output logic [64*NUM_BUFFERS-1:0]     buf_addr,
  output logic [SIZE_W*NUM_BUFFERS-1:0] buf_size,
  output logic [1:0]                    ctl_state,
  output logic                          start_pulse,
  output logic                          stop_pulse
);

  // Register locations expressed as dword addresses (byte address >> 2).
  localparam logic [15:0] DSM_DW  = 16'h0044;
  localparam logic [15:0] CTL_DW  = 16'h0046;
  localparam logic [15:0] BASE_DW = {2'b00, BASE_ADDR[15:2]};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctlState_t;

  ctlState_t         r_state;
  logic              r_startPulse;
  logic              r_stopPulse;
  logic [63:0]       r_dsm;
  logic [63:0]       r_bufAddr [NUM_BUFFERS];
  logic [SIZE_W-1:0] r_bufSize [NUM_BUFFERS];
  logic              r_rspValid;
  logic [8:0]        r_rspTid;
  logic [63:0]       r_rspData;

  logic                   w_inWindow;
  logic                   w_dsmHit;
  logic                   w_ctlHit;
  logic [NUM_BUFFERS-1:0] w_addrHit;
  logic [NUM_BUFFERS-1:0] w_sizeHit;
  logic                   w_dataWrEn;
  logic [63:0]            w_rdData;

  // Only 8-byte aligned locations below byte 0x400 are mapped; anything else
  // (odd dword addresses, aliases above the window) decodes to nothing.
  assign w_inWindow = (mmio_addr[0] == 1'b0) && (mmio_addr[15:8] == 8'h00);
  assign w_dsmHit   = w_inWindow && (mmio_addr == DSM_DW);
  assign w_ctlHit   = w_inWindow && (mmio_addr == CTL_DW);

  // Descriptor and DSM contents are frozen while the channel is running.
  assign w_dataWrEn = mmio_wr_valid && (r_state != RUN);

  // Per-descriptor address/size decode; indices past NUM_BUFFERS never match.
  always_comb begin
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      w_addrHit[i] = w_inWindow && (mmio_addr == 16'(BASE_DW + 16'(4 * i)));
      w_sizeHit[i] = w_inWindow && (mmio_addr == 16'(BASE_DW + 16'(4 * i + 2)));
    end
  end

  // Read data mux; reads see the register values before any same-cycle write.
  always_comb begin
    w_rdData = 64'h0;
`ifdef HC_CSR_READBACK_EN
    if (w_dsmHit) w_rdData = r_dsm;
    if (w_ctlHit) w_rdData = {62'h0, r_state};
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (w_addrHit[i]) w_rdData = r_bufAddr[i];
      if (w_sizeHit[i]) w_rdData = 64'(r_bufSize[i]);
    end
`endif
  end

  // DSM and descriptor register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dsm <= 64'h0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        r_bufAddr[i] <= 64'h0;
        r_bufSize[i] <= '0;
      end
    end else if (w_dataWrEn) begin
      if (w_dsmHit) r_dsm <= mmio_wdata;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (w_addrHit[i]) r_bufAddr[i] <= mmio_wdata;
        if (w_sizeHit[i]) r_bufSize[i] <= mmio_wdata[SIZE_W-1:0];
      end
    end
  end

  // Control FSM with registered one-cycle start/stop strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_startPulse <= 1'b0;
      r_stopPulse  <= 1'b0;
    end else begin
      r_startPulse <= 1'b0;
      r_stopPulse  <= 1'b0;
      if (mmio_wr_valid && w_ctlHit) begin
        case (mmio_wdata[31:0])
          32'h0: r_state <= IDLE;
          32'h1: begin
            if (r_state == IDLE || r_state == DONE) r_state <= READY;
          end
          32'h3: begin
            if (r_state == READY) begin
              r_state      <= RUN;
              r_startPulse <= 1'b1;
            end
          end
          32'h7: begin
            if (r_state == RUN) begin
              r_state     <= DONE;
              r_stopPulse <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read response register: one cycle latency, tid echoed, reset drops it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rspValid <= 1'b0;
      r_rspTid   <= 9'h0;
      r_rspData  <= 64'h0;
    end else begin
      r_rspValid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        r_rspTid  <= mmio_tid;
        r_rspData <= w_rdData;
      end
    end
  end

  assign rsp_valid   = r_rspValid;
  assign rsp_tid     = r_rspTid;
  assign rsp_data    = r_rspData;
  assign dsm_base    = r_dsm;
  assign ctl_state   = r_state;
  assign start_pulse = r_startPulse;
  assign stop_pulse  = r_stopPulse;

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : gPack
    assign buf_addr[64*g +: 64]         = r_bufAddr[g];
    assign buf_size[SIZE_W*g +: SIZE_W] = r_bufSize[g];
  end

endmodule

// File: tb/tb_hc_csr_bank.sv
// tb_hc_csr_bank: directed self-checking bench for hc_csr_bank with default
// parameters. Read responses are predicted into a scoreboard queue when the
// read is driven and popped when the response cycle arrives.
module tb_hc_csr_bank;

  localparam int NB = 4;
  localparam int SW = 32;

`ifdef HC_CSR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              mmio_wr_valid;
  logic              mmio_rd_valid;
  logic [15:0]       mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wdata;
  logic              rsp_valid;
  logic [8:0]        rsp_tid;
  logic [63:0]       rsp_data;
  logic [63:0]       dsm_base;
  logic [64*NB-1:0]  buf_addr;
  logic [SW*NB-1:0]  buf_size;
  logic [1:0]        ctl_state;
  logic              start_pulse;
  logic              stop_pulse;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  rsp_t scoreQ[$];

  int checkCount = 0;
  int passCount  = 0;

  logic [63:0] expDsm;
  logic [63:0] expAddr [NB];
  logic [SW-1:0] expSize [NB];
  logic [1:0]  expState;

  hc_csr_bank #(
    .NUM_BUFFERS(NB),
    .BASE_ADDR  (16'h120),
    .SIZE_W     (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr    (mmio_addr),
    .mmio_tid     (mmio_tid),
    .mmio_wdata   (mmio_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_tid      (rsp_tid),
    .rsp_data     (rsp_data),
    .dsm_base     (dsm_base),
    .buf_addr     (buf_addr),
    .buf_size     (buf_size),
    .ctl_state    (ctl_state),
    .start_pulse  (start_pulse),
    .stop_pulse   (stop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic checkRegs(input string tag);
    logic [64*NB-1:0] packedAddr;
    logic [SW*NB-1:0] packedSize;
    for (int i = 0; i < NB; i++) begin
      packedAddr[64*i +: 64] = expAddr[i];
      packedSize[SW*i +: SW] = expSize[i];
    end
    checkOutput({tag, "_dsm"}, dsm_base, expDsm);
    checkOutput({tag, "_state"}, 64'(ctl_state), 64'(expState));
    assert (buf_addr === packedAddr) begin
      checkCount++; passCount++;
    end else begin
      checkCount++;
      $error("[TB] FAIL %s_buf_addr observed=0x%0h expected=0x%0h", tag, buf_addr, packedAddr);
    end
    checkOutput({tag, "_buf_size"}, 64'(buf_size), 64'(packedSize));
  endtask

  // One clock of MMIO traffic; a read pushes its prediction and its response
  // is checked right after the edge, and a cycle without a read must not
  // produce a response.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [17:0] byteAddr,
                               input logic [63:0] wdata, input logic [8:0] tid,
                               input logic [63:0] expRead, input string tag);
    rsp_t r;
    rsp_t e;
    if (rd) begin
      r.tid  = tid;
      r.data = RB ? expRead : 64'h0;
      scoreQ.push_back(r);
    end
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = byteAddr[17:2];
    mmio_wdata    = wdata;
    mmio_tid      = tid;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(rd));
    if (rd && scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput({tag, "_rsp_tid"}, 64'(rsp_tid), 64'(e.tid));
      checkOutput({tag, "_rsp_data"}, rsp_data, e.data);
    end
  endtask

  task automatic ctlWrite(input logic [63:0] value, input string tag);
    applyStimulus(1'b1, 1'b0, 18'h118, value, 9'h0, 64'h0, tag);
  endtask

  initial begin
    reset         = 1'b1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    mmio_addr     = 16'h0;
    mmio_tid      = 9'h0;
    mmio_wdata    = 64'h0;
    expDsm        = 64'h0;
    expState      = 2'd0;
    for (int i = 0; i < NB; i++) begin
      expAddr[i] = 64'h0;
      expSize[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkRegs("reset");
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_pulses", 64'({start_pulse, stop_pulse}), 64'h0);

    // Descriptor 0 address then size (upper write bits must be dropped)
    applyStimulus(1'b1, 1'b0, 18'h120, 64'h1000, 9'h0, 64'h0, "wr_addr0");
    expAddr[0] = 64'h1000;
    checkRegs("addr0");
    applyStimulus(1'b1, 1'b0, 18'h128, 64'hFFFF_FFFF_0000_0040, 9'h0, 64'h0, "wr_size0");
    expSize[0] = 32'h40;
    checkRegs("size0");

    // DSM write and readback
    applyStimulus(1'b1, 1'b0, 18'h110, 64'hABCD000, 9'h0, 64'h0, "wr_dsm");
    expDsm = 64'hABCD000;
    checkRegs("dsm");
    applyStimulus(1'b0, 1'b1, 18'h110, 64'h0, 9'h012, 64'hABCD000, "rd_dsm");

    // Last descriptor
    applyStimulus(1'b1, 1'b0, 18'h150, 64'h1234_5678_9ABC_3333, 9'h0, 64'h0, "wr_addr3");
    expAddr[3] = 64'h1234_5678_9ABC_3333;
    applyStimulus(1'b1, 1'b0, 18'h158, 64'h99, 9'h0, 64'h0, "wr_size3");
    expSize[3] = 32'h99;
    checkRegs("desc3");
    applyStimulus(1'b0, 1'b1, 18'h158, 64'h0, 9'h1FF, 64'h99, "rd_size3");

    // Out-of-range descriptor, odd address and aliased address are ignored
    applyStimulus(1'b1, 1'b0, 18'h160, 64'hDEAD, 9'h0, 64'h0, "wr_desc4");
    applyStimulus(1'b1, 1'b0, 18'h124, 64'hBAD1, 9'h0, 64'h0, "wr_odd");
    applyStimulus(1'b1, 1'b0, 18'h520, 64'hBAD2, 9'h0, 64'h0, "wr_alias");
    checkRegs("ignored");
    applyStimulus(1'b0, 1'b1, 18'h160, 64'h0, 9'h055, 64'h0, "rd_desc4");
    applyStimulus(1'b0, 1'b1, 18'h124, 64'h0, 9'h0A5, 64'h0, "rd_odd");

    // FSM: illegal 0x3 in IDLE, then IDLE->READY, illegal 0x7 in READY
    ctlWrite(64'h3, "ctl3_idle");
    checkOutput("ctl3_idle_start", 64'(start_pulse), 64'h0);
    checkRegs("ctl3_idle");
    ctlWrite(64'h1, "ctl1");
    expState = 2'd1;
    checkRegs("ctl1");
    ctlWrite(64'h7, "ctl7_ready");
    checkOutput("ctl7_ready_stop", 64'(stop_pulse), 64'h0);
    checkRegs("ctl7_ready");

    // READY->RUN with a one-cycle start strobe
    ctlWrite(64'h3, "ctl3");
    expState = 2'd2;
    checkOutput("ctl3_start", 64'(start_pulse), 64'h1);
    checkRegs("ctl3");
    applyStimulus(1'b0, 1'b1, 18'h118, 64'h0, 9'h0C0, 64'h2, "rd_ctl_run");
    checkOutput("start_drop", 64'(start_pulse), 64'h0);

    // Data writes frozen in RUN
    applyStimulus(1'b1, 1'b0, 18'h130, 64'hBEEF, 9'h0, 64'h0, "run_wr_addr1");
    applyStimulus(1'b1, 1'b0, 18'h110, 64'h5555, 9'h0, 64'h0, "run_wr_dsm");
    checkRegs("run_frozen");

    // RUN->DONE with a one-cycle stop strobe, DONE->READY, junk value, ->IDLE
    ctlWrite(64'h7, "ctl7");
    expState = 2'd3;
    checkOutput("ctl7_stop", 64'(stop_pulse), 64'h1);
    checkRegs("ctl7");
    applyStimulus(1'b0, 1'b1, 18'h118, 64'h0, 9'h0C1, 64'h3, "rd_ctl_done");
    checkOutput("stop_drop", 64'(stop_pulse), 64'h0);
    ctlWrite(64'h1, "ctl1_done");
    expState = 2'd1;
    checkRegs("ctl1_done");
    ctlWrite(64'h5, "ctl5");
    checkRegs("ctl5");
    ctlWrite(64'h1_0000_0000, "ctl_upper");
    expState = 2'd0;
    checkRegs("ctl_upper");

    // Read and write of the same register in one cycle returns the old value
    applyStimulus(1'b1, 1'b1, 18'h120, 64'h2222, 9'h1AB, 64'h1000, "rdwr_addr0");
    expAddr[0] = 64'h2222;
    checkRegs("rdwr");

    // Back into RUN, then reset with a read pending
    ctlWrite(64'h1, "rerun1");
    ctlWrite(64'h3, "rerun3");
    expState = 2'd2;
    checkRegs("rerun");
    reset         = 1'b1;
    mmio_rd_valid = 1'b1;
    mmio_addr     = 16'h0046;
    mmio_tid      = 9'h077;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    mmio_rd_valid = 1'b0;
    expState = 2'd0;
    expDsm   = 64'h0;
    for (int i = 0; i < NB; i++) begin
      expAddr[i] = 64'h0;
      expSize[i] = '0;
    end
    checkRegs("rst_run");
    checkOutput("rst_run_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_run_rsp_tid", 64'(rsp_tid), 64'h0);
    checkOutput("rst_run_rsp_data", rsp_data, 64'h0);
    checkOutput("rst_run_pulses", 64'({start_pulse, stop_pulse}), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_after_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("rst_after_stop", 64'(stop_pulse), 64'h0);
    checkOutput("scoreboard_empty", 64'(scoreQ.size()), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
